regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the Hunter_RV32 datapath. It replaces the fixed 32x32 two-port array: data width, depth and read-port count are configurable, and there are two write ports with defined conflict resolution. It adds optional same-cycle write-to-read bypass and a self-clearing scrub sequencer that zeroes the array after reset or on request. It sits between decode (read addresses) and writeback (write ports).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value
- ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  request a scrub of the whole array (sampled only in READY)
- ready  out  1  array valid and accepting writes
- we  in  2  write enables; bit 0 = port A, bit 1 = port B
- waddr  in  2*ADDR_W  write addresses; port A in [ADDR_W-1:0]
- wdata  in  2*DATA_W  write data; port A in [DATA_W-1:0]
- raddr  in  NRD*ADDR_W  read addresses, port i in slice i
- rdata  out  NRD*DATA_W  read data, port i in slice i
- conflict  out  1  registered flag: previous cycle had both ports writing the same non-ignored address

## Operation
- FSM states: CLEAR and READY. Scrub counter is ADDR_W bits wide.
- rst asserted: state = CLEAR, counter = 0, conflict = 0. The array contents are not reset directly.
- CLEAR, each posedge: mem[counter] <= 0, counter += 1. The edge that clears entry DEPTH-1 moves the state to READY, and counter wraps to 0.
- In CLEAR: ready = 0, we ignored, all rdata = 0, and clear has no effect.
- READY with clear = 1 at a posedge: the state goes to CLEAR with counter = 0. Writes presented in that same cycle are still performed. Scrub starts at the next edge.
- Writes happen only in READY, on the posedge.
- When we[p] = 1, mem[waddr_p] <= wdata_p, unless ZERO_REG = 1 and waddr_p = 0; then the write is discarded.
- Both ports writing the same address: port B wins. conflict = 1 on the following cycle only if that address is not discarded, and is cleared otherwise.
- Reads are combinational (asynchronous). rdata_i = mem[raddr_i], with these overrides:
  - ZERO_REG = 1 and raddr_i = 0 gives 0.
  - BYPASS = 1 and READY: if we[1] and waddr_B = raddr_i, return wdata_B. Else if we[0] and waddr_A = raddr_i, return wdata_A. Bypass does not apply to a discarded entry 0.
  - Not READY gives 0.
- Unlike the previous block, a read is never forced to zero just because a write is active.

## Timing
- Reset values: ready = 0, conflict = 0, all rdata = 0, state = CLEAR, counter = 0.
- After rst deasserts, ready rises after exactly DEPTH posedges (32 for default). The first write is accepted at edge DEPTH+1.
- Write latency: stored value visible at rdata the cycle after the write edge. With BYPASS = 1 it is visible combinationally in the same cycle.
- conflict is asserted for exactly one cycle per conflicting write cycle.
- clear in READY: ready falls after that edge. It returns after another DEPTH edges.
- rst asserted mid-scrub or mid-operation: immediate return to CLEAR, counter = 0, ready = 0. The scrub restarts from entry 0.
- No combinational path from rst to rdata other than through ready/state.

## Test plan
- Reset then idle: ready = 0 for 32 edges, ready = 1 after the 32nd; reading all 32 addresses gives 0.
- Port A writes 0xDEADBEEF to x5; next cycle raddr0 = 5 gives 0xDEADBEEF. With BYPASS = 1, rdata0 = 0xDEADBEEF during the write cycle; with BYPASS = 0 it shows the old value 0.
- A and B both write x7 (0x11111111 and 0x22222222): x7 = 0x22222222 and conflict = 1 for one cycle. The same pair targeting x0 leaves x0 = 0 with conflict = 0.
- Write x0 = 0xFFFFFFFF with ZERO_REG = 1: rdata = 0 in the same cycle and afterwards. With ZERO_REG = 0, x0 reads 0xFFFFFFFF.
- Fill x1..x31, pulse clear: ready falls, writes during CLEAR are ignored, and after 32 edges all entries read 0.
- Assert rst at scrub edge 10, release, and check ready returns exactly 32 edges after release. Repeat with NRD = 4, DATA_W = 64, ADDR_W = 3: ready after 8 edges, and all four ports read independent addresses correctly.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (B wins on a collision), NRD combinational read ports, and a scrub sequencer.
// Latency: reads are combinational. Writes land on the posedge. With BYPASS, write data is forwarded to matching reads in the same cycle.
// Backpressure: ready is low while the scrubber owns the array. Writes are dropped during that time and reads return zero.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  output logic                  ready,
  input  logic [1:0]            we,
  input  logic [2*ADDR_W-1:0]   waddr,
  input  logic [2*DATA_W-1:0]   wdata,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic                  conflict
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ENTRY = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [ADDR_W-1:0] scrubCnt;
  logic [ADDR_W-1:0] scrubCntNext;
  logic              isReady;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] waddrA;
  logic [ADDR_W-1:0] waddrB;
  logic [DATA_W-1:0] wdataA;
  logic [DATA_W-1:0] wdataB;
  logic              dropA;
  logic              dropB;
  logic              wrA;
  logic              wrB;
  logic              conflictNext;

  assign waddrA = waddr[ADDR_W-1:0];
  assign waddrB = waddr[2*ADDR_W-1:ADDR_W];
  assign wdataA = wdata[DATA_W-1:0];
  assign wdataB = wdata[2*DATA_W-1:DATA_W];

  assign isReady = (state == READY);

  // A write to entry 0 is discarded when entry 0 is hardwired to zero.
  assign dropA = ZERO_REG && (waddrA == '0);
  assign dropB = ZERO_REG && (waddrB == '0);

  // Effective writes. These qualify storage, bypass and conflict detection alike.
  assign wrA = isReady && we[0] && !dropA;
  assign wrB = isReady && we[1] && !dropB;

  // A conflict is only real when both ports would actually land on the same entry.
  assign conflictNext = wrA && wrB && (waddrA == waddrB);

  // State and scrub counter registers. Reset restarts the scrub from entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      scrubCnt <= '0;
    end else begin
      state    <= stateNext;
      scrubCnt <= scrubCntNext;
    end
  end

  // Next-state logic. The scrub walks every entry once, then hands the array over. A clear request while READY restarts it.
  always_comb begin
    stateNext    = state;
    scrubCntNext = scrubCnt;
    ready        = 1'b0;
    case (state)
      CLEAR: begin
        scrubCntNext = scrubCnt + 1'b1;
        if (scrubCnt == LAST_ENTRY) begin
          stateNext = READY;
        end
      end
      READY: begin
        ready = 1'b1;
        if (clear) begin
          stateNext    = CLEAR;
          scrubCntNext = '0;
        end
      end
      default: begin
        stateNext    = CLEAR;
        scrubCntNext = '0;
      end
    endcase
  end

  // One-cycle conflict flag for the cycle after a colliding write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict <= 1'b0;
    end else begin
      conflict <= conflictNext;
    end
  end

  // Array update. The scrubber zeroes one entry per edge; otherwise port A then port B, so B wins on a shared address.
  always_ff @(posedge clk) begin
    if (!isReady) begin
      mem[scrubCnt] <= '0;
    end else begin
      if (wrA) begin
        mem[waddrA] <= wdataA;
      end
      if (wrB) begin
        mem[waddrB] <= wdataB;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : gRead
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[i*ADDR_W +: ADDR_W];

    // Read mux: zero while scrubbing or for a hardwired entry 0, otherwise forward in-flight data (B before A), else stored data.
    always_comb begin
      rd = mem[ra];
      if (!isReady) begin
        rd = '0;
      end else if (ZERO_REG && (ra == '0)) begin
        rd = '0;
      end else if (BYPASS && wrB && (waddrB == ra)) begin
        rd = wdataB;
      end else if (BYPASS && wrA && (waddrA == ra)) begin
        rd = wdataA;
      end
    end

    assign rdata[i*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. It runs the default configuration, a no-bypass/no-zero-reg variant, and a narrow/wide four-read-port variant.
// Expected values are hand-computed constants plus a small data-pattern function for the four-port instance.
// Reset and clear timing are measured by counting edges until ready rises, each count bounded.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Default configuration
  logic         clear0, ready0, conflict0;
  logic [1:0]   we0;
  logic [9:0]   waddr0, raddr0;
  logic [63:0]  wdata0, rdata0;

  // BYPASS = 0, ZERO_REG = 0
  logic         clear1, ready1, conflict1;
  logic [1:0]   we1;
  logic [9:0]   waddr1, raddr1;
  logic [63:0]  wdata1, rdata1;

  // NRD = 4, DATA_W = 64, ADDR_W = 3
  logic         clear2, ready2, conflict2;
  logic [1:0]   we2;
  logic [5:0]   waddr2;
  logic [127:0] wdata2;
  logic [11:0]  raddr2;
  logic [255:0] rdata2;

  int checkCnt = 0;
  int errCnt   = 0;

  regfile_mp dut0 (
    .clk(clk), .rst(rst), .clear(clear0), .ready(ready0), .we(we0),
    .waddr(waddr0), .wdata(wdata0), .raddr(raddr0), .rdata(rdata0), .conflict(conflict0)
  );

  regfile_mp #(.BYPASS(1'b0), .ZERO_REG(1'b0)) dut1 (
    .clk(clk), .rst(rst), .clear(clear1), .ready(ready1), .we(we1),
    .waddr(waddr1), .wdata(wdata1), .raddr(raddr1), .rdata(rdata1), .conflict(conflict1)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(3), .NRD(4)) dut2 (
    .clk(clk), .rst(rst), .clear(clear2), .ready(ready2), .we(we2),
    .waddr(waddr2), .wdata(wdata2), .raddr(raddr2), .rdata(rdata2), .conflict(conflict2)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] val2(input int i);
    return {32'hC0DE0000 | 32'(i), 32'h0BAD0000 | 32'(i * 3)};
  endfunction

  int e0, e1, e2, cnt;
  logic [2:0] ra2 [4];

  initial begin
    rst = 1'b1;
    clear0 = 1'b0; we0 = '0; waddr0 = '0; wdata0 = '0; raddr0 = {5'd5, 5'd3};
    clear1 = 1'b0; we1 = '0; waddr1 = '0; wdata1 = '0; raddr1 = '0;
    clear2 = 1'b0; we2 = '0; waddr2 = '0; wdata2 = '0; raddr2 = '0;

    // Reset state
    #1;
    checkVal("rst_ready0", 64'(ready0), 64'd0);
    checkVal("rst_conflict0", 64'(conflict0), 64'd0);
    checkVal("rst_rdata0", rdata0, 64'd0);
    checkVal("rst_ready2", 64'(ready2), 64'd0);
    #11;
    rst = 1'b0;

    // Post-reset scrub length
    e0 = 0; e1 = 0; e2 = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (ready0 && e0 == 0) e0 = e;
      if (ready1 && e1 == 0) e1 = e;
      if (ready2 && e2 == 0) e2 = e;
    end
    checkVal("rst_edges0", 64'(e0), 64'd32);
    checkVal("rst_edges1", 64'(e1), 64'd32);
    checkVal("rst_edges2", 64'(e2), 64'd8);

    // Whole array reads zero after the initial scrub
    for (int i = 0; i < 32; i++) begin
      raddr0 = {5'(31 - i), 5'(i)};
      #1;
      checkVal("idle_rd", rdata0, 64'd0);
    end
    tick();

    // Single write to x5: bypass vs. stored value
    we0 = 2'b01; waddr0 = {5'd0, 5'd5}; wdata0 = {32'h0, 32'hDEADBEEF}; raddr0 = {5'd5, 5'd5};
    we1 = 2'b01; waddr1 = {5'd0, 5'd5}; wdata1 = {32'h0, 32'hDEADBEEF}; raddr1 = {5'd5, 5'd5};
    #1;
    checkVal("x5_byp_same", 64'(rdata0[31:0]), 64'hDEADBEEF);
    checkVal("x5_nobyp_same", 64'(rdata1[31:0]), 64'd0);
    tick();
    we0 = '0; we1 = '0;
    #1;
    checkVal("x5_after0", 64'(rdata0[31:0]), 64'hDEADBEEF);
    checkVal("x5_after1", 64'(rdata1[31:0]), 64'hDEADBEEF);

    // Two writes to different addresses, each forwarded to its own read port
    we0 = 2'b11; waddr0 = {5'd4, 5'd3}; wdata0 = {32'h44444444, 32'h33333333}; raddr0 = {5'd4, 5'd3};
    #1;
    checkVal("byp_a", 64'(rdata0[31:0]), 64'h33333333);
    checkVal("byp_b", 64'(rdata0[63:32]), 64'h44444444);
    tick();
    we0 = '0;
    #1;
    checkVal("ab_noconf", 64'(conflict0), 64'd0);
    checkVal("ab_stored", rdata0, {32'h44444444, 32'h33333333});

    // Collision on x7: B wins, and an unrelated read during the writes is unaffected
    we0 = 2'b11; waddr0 = {5'd7, 5'd7}; wdata0 = {32'h22222222, 32'h11111111}; raddr0 = {5'd5, 5'd7};
    #1;
    checkVal("conf_byp", 64'(rdata0[31:0]), 64'h22222222);
    checkVal("conf_other_rd", 64'(rdata0[63:32]), 64'hDEADBEEF);
    tick();
    we0 = '0;
    #1;
    checkVal("conf_flag", 64'(conflict0), 64'd1);
    checkVal("conf_x7", 64'(rdata0[31:0]), 64'h22222222);
    tick();
    checkVal("conf_one_cycle", 64'(conflict0), 64'd0);

    // Collision on x0: discarded with ZERO_REG = 1, a real conflict with ZERO_REG = 0
    we0 = 2'b11; waddr0 = '0; wdata0 = {32'h22222222, 32'h11111111}; raddr0 = '0;
    we1 = 2'b11; waddr1 = '0; wdata1 = {32'h22222222, 32'h11111111}; raddr1 = '0;
    #1;
    checkVal("x0_pair_same", rdata0, 64'd0);
    tick();
    we0 = '0; we1 = '0;
    #1;
    checkVal("x0_pair_noconf", 64'(conflict0), 64'd0);
    checkVal("x0_pair_after", rdata0, 64'd0);
    checkVal("x0_pair_conf_zr0", 64'(conflict1), 64'd1);
    checkVal("x0_pair_zr0", 64'(rdata1[31:0]), 64'h22222222);

    // Port A writes all ones to x0
    we0 = 2'b01; waddr0 = '0; wdata0 = {32'h0, 32'hFFFFFFFF};
    we1 = 2'b01; waddr1 = '0; wdata1 = {32'h0, 32'hFFFFFFFF};
    #1;
    checkVal("x0ff_same", 64'(rdata0[31:0]), 64'd0);
    tick();
    we0 = '0; we1 = '0;
    #1;
    checkVal("x0ff_after", 64'(rdata0[31:0]), 64'd0);
    checkVal("x0ff_zr0", 64'(rdata1[31:0]), 64'hFFFFFFFF);

    // Fill x1..x31, then scrub on request
    for (int i = 1; i < 32; i++) begin
      we0 = 2'b01; waddr0 = {5'd0, 5'(i)}; wdata0 = {32'h0, 32'h100 + 32'(i)};
      tick();
    end
    we0 = '0;
    raddr0 = {5'd1, 5'd31};
    #1;
    checkVal("fill_rd", rdata0, {32'h101, 32'h11F});
    clear0 = 1'b1;
    tick();
    clear0 = 1'b0;
    checkVal("clr_ready", 64'(ready0), 64'd0);
    checkVal("clr_rd", rdata0, 64'd0);
    // Writes to x2 and a held clear during the scrub must both be ignored
    cnt = 0;
    for (int e = 1; e <= 40 && cnt == 0; e++) begin
      clear0 = (e >= 5 && e <= 20);
      we0 = 2'b01; waddr0 = {5'd0, 5'd2}; wdata0 = {32'h0, 32'h0BADBAD0};
      tick();
      if (ready0) cnt = e;
    end
    we0 = '0; clear0 = 1'b0;
    checkVal("clr_edges", 64'(cnt), 64'd32);
    for (int i = 0; i < 32; i++) begin
      raddr0 = {5'(i), 5'(i)};
      #1;
      checkVal("clr_scrubbed_rd", rdata0, 64'd0);
    end
    tick();

    // Four-port instance: fill all 8 entries in pairs, then read independent addresses
    for (int k = 0; k < 4; k++) begin
      we2 = 2'b11; waddr2 = {3'(2 * k + 1), 3'(2 * k)}; wdata2 = {val2(2 * k + 1), val2(2 * k)};
      tick();
    end
    we2 = '0;
    for (int pat = 0; pat < 2; pat++) begin
      if (pat == 0) begin
        ra2[0] = 3'd7; ra2[1] = 3'd2; ra2[2] = 3'd5; ra2[3] = 3'd0;
      end else begin
        ra2[0] = 3'd4; ra2[1] = 3'd3; ra2[2] = 3'd6; ra2[3] = 3'd1;
      end
      raddr2 = {ra2[3], ra2[2], ra2[1], ra2[0]};
      #1;
      for (int p = 0; p < 4; p++) begin
        checkVal("nrd4_rd", rdata2[p*64 +: 64], (ra2[p] == 3'd0) ? 64'd0 : val2(int'(ra2[p])));
      end
    end
    tick();

    // Reset at scrub edge 10 of dut0, while dut2 is mid-operation
    clear0 = 1'b1;
    tick();
    clear0 = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    rst = 1'b1;
    #1;
    checkVal("rst_mid_ready0", 64'(ready0), 64'd0);
    checkVal("rst_mid_ready2", 64'(ready2), 64'd0);
    checkVal("rst_mid_rd2", rdata2[63:0], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    e0 = 0; e2 = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (ready0 && e0 == 0) e0 = e;
      if (ready2 && e2 == 0) e2 = e;
    end
    checkVal("rst_mid_edges0", 64'(e0), 64'd32);
    checkVal("rst_mid_edges2", 64'(e2), 64'd8);
    #1;
    checkVal("rst_mid_scrub2_p0", rdata2[63:0], 64'd0);
    checkVal("rst_mid_scrub2_p2", rdata2[191:128], 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule
